// File: rtl/drive_ctrl.sv
// drive_ctrl: two-motor H-bridge controller with a shared free-running PWM and the drive FSM.
// Optional dead-time on bridge in-pair changes is built when DRIVE_DEADTIME_EN is defined.

module drive_ctrl #(
    parameter int unsigned CLK_HZ        = 50_000_000,
    parameter int unsigned PWM_HZ        = 80,
    parameter int unsigned CNT_W         = 20,
    parameter int unsigned FULL_PCT      = 80,
    parameter int unsigned VEER_PCT      = 40,
    parameter int unsigned MAX_PCT       = 80,
    parameter int unsigned TURN_CYCLES   = 25_000_000,
    parameter int unsigned REV_CYCLES    = 50_000_000,
    parameter int unsigned JUNCT_TIMEOUT = 100_000_000,
    parameter int unsigned DEAD_CYCLES   = 500
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] dir,
    input  logic       col_detect,
    input  logic       junction,
    input  logic       tone_valid,
    input  logic [2:0] tone_code,
    output logic       hb_en_a,
    output logic       hb_en_b,
    output logic       hb_in1,
    output logic       hb_in2,
    output logic       hb_in3,
    output logic       hb_in4,
    output logic [2:0] state,
    output logic       pwm_dbg
);

    localparam int unsigned PERIOD   = CLK_HZ / PWM_HZ;
    localparam int unsigned FULL_EFF = (FULL_PCT < MAX_PCT) ? FULL_PCT : MAX_PCT;
    localparam int unsigned VEER_EFF = (VEER_PCT < MAX_PCT) ? VEER_PCT : MAX_PCT;
    localparam longint unsigned ON_FULL_L = 64'(PERIOD) * 64'(FULL_EFF) / 64'd100;
    localparam longint unsigned ON_VEER_L = 64'(PERIOD) * 64'(VEER_EFF) / 64'd100;
    localparam logic [CNT_W:0]   ON_FULL  = (CNT_W+1)'(ON_FULL_L);
    localparam logic [CNT_W:0]   ON_VEER  = (CNT_W+1)'(ON_VEER_L);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);

    localparam int unsigned TMR_MAX0 = (TURN_CYCLES > REV_CYCLES) ? TURN_CYCLES : REV_CYCLES;
    localparam int unsigned TMR_MAX  = (TMR_MAX0 > JUNCT_TIMEOUT) ? TMR_MAX0 : JUNCT_TIMEOUT;
    localparam int unsigned TMR_W    = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
    localparam logic [TMR_W-1:0] TURN_LAST  = TMR_W'(TURN_CYCLES - 1);
    localparam logic [TMR_W-1:0] REV_LAST   = TMR_W'(REV_CYCLES - 1);
    localparam logic [TMR_W-1:0] JUNCT_LAST = TMR_W'(JUNCT_TIMEOUT - 1);

    // In-pair codes: side A is {in1,in2}, side B is {in3,in4}
    localparam logic [1:0] A_FWD = 2'b01;
    localparam logic [1:0] A_REV = 2'b10;
    localparam logic [1:0] B_FWD = 2'b10;
    localparam logic [1:0] B_REV = 2'b01;

    typedef enum logic [2:0] {
        FWD   = 3'd0,
        COLL  = 3'd1,
        JUNCT = 3'd2,
        TURN  = 3'd3,
        REV   = 3'd4,
        HALT  = 3'd5
    } driveState_t;

    driveState_t      stateQ, stateNext;
    logic [TMR_W-1:0] timer;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       dirQ;
    logic             turnLeft;
    logic             pwmFull, pwmVeer;

    logic [1:0][1:0]  reqPair;
    logic [1:0]       reqRun, reqVeer, reqEn;

    logic [1:0]       enQ;
    logic [1:0][1:0]  pairQ;
    logic             pwmDbgQ;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign pwmFull = ({1'b0, cnt} < ON_FULL);
    assign pwmVeer = ({1'b0, cnt} < ON_VEER);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ   <= FWD;
            timer    <= '0;
            dirQ     <= '0;
            turnLeft <= 1'b0;
        end else begin
            stateQ <= stateNext;
            dirQ   <= dir;
            if (stateNext != stateQ) begin
                timer <= '0;
            end else if (stateQ == JUNCT || stateQ == TURN || stateQ == REV) begin
                timer <= timer + 1'b1;
            end
            if (stateQ == JUNCT && stateNext == TURN) begin
                turnLeft <= (tone_code == 3'd2);
            end
        end
    end

    always_comb begin
        stateNext = stateQ;
        case (stateQ)
            FWD: begin
                if (col_detect)    stateNext = COLL;
                else if (junction) stateNext = JUNCT;
            end
            COLL: begin
                if (!col_detect) stateNext = FWD;
            end
            JUNCT: begin
                // collision beats tone, tone beats the timeout in the same cycle
                if (col_detect) begin
                    stateNext = COLL;
                end else if (tone_valid) begin
                    case (tone_code)
                        3'd1:       stateNext = FWD;
                        3'd2, 3'd3: stateNext = TURN;
                        3'd4:       stateNext = REV;
                        default:    stateNext = HALT;
                    endcase
                end else if (timer == JUNCT_LAST) begin
                    stateNext = HALT;
                end
            end
            TURN: begin
                if (col_detect)              stateNext = COLL;
                else if (timer == TURN_LAST) stateNext = FWD;
            end
            REV: begin
                if (col_detect)             stateNext = COLL;
                else if (timer == REV_LAST) stateNext = FWD;
            end
            HALT:    stateNext = HALT;
            default: stateNext = HALT;
        endcase
    end

    always_comb begin
        reqPair = '0;
        reqRun  = '0;
        reqVeer = '0;
        case (stateQ)
            FWD: begin
                if (dirQ != 2'b11) begin
                    reqRun     = 2'b11;
                    reqPair[0] = A_FWD;
                    reqPair[1] = B_FWD;
                    reqVeer[0] = (dirQ == 2'b01);
                    reqVeer[1] = (dirQ == 2'b10);
                end
            end
            TURN: begin
                reqRun  = 2'b11;
                reqVeer = 2'b11;
                if (turnLeft) begin
                    reqPair[0] = A_REV;
                    reqPair[1] = B_FWD;
                end else begin
                    reqPair[0] = A_FWD;
                    reqPair[1] = B_REV;
                end
            end
            REV: begin
                reqRun     = 2'b11;
                reqVeer    = 2'b11;
                reqPair[0] = A_REV;
                reqPair[1] = B_REV;
            end
            default: ;
        endcase
        reqEn[0] = reqRun[0] & (reqVeer[0] ? pwmVeer : pwmFull);
        reqEn[1] = reqRun[1] & (reqVeer[1] ? pwmVeer : pwmFull);
    end

`ifdef DRIVE_DEADTIME_EN
    localparam int unsigned DEAD_W = (DEAD_CYCLES >= 2) ? $clog2(DEAD_CYCLES) : 1;
    localparam logic [DEAD_W-1:0] DEAD_LOAD = DEAD_W'((DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0);

    logic [1:0][1:0]        curPair;
    logic [1:0][DEAD_W-1:0] deadCnt;
    logic [1:0]             changeReq, gapNow;

    // The change cycle itself is the first gap cycle, so the counter loads DEAD_CYCLES-1
    always_comb begin
        changeReq[0] = (reqPair[0] != curPair[0]);
        changeReq[1] = (reqPair[1] != curPair[1]);
        gapNow[0]    = (DEAD_CYCLES != 0) && (changeReq[0] || (deadCnt[0] != '0));
        gapNow[1]    = (DEAD_CYCLES != 0) && (changeReq[1] || (deadCnt[1] != '0));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            curPair <= '0;
            deadCnt <= '0;
            enQ     <= '0;
            pairQ   <= '0;
            pwmDbgQ <= 1'b0;
        end else begin
            curPair    <= reqPair;
            deadCnt[0] <= changeReq[0] ? DEAD_LOAD : ((deadCnt[0] != '0) ? deadCnt[0] - 1'b1 : '0);
            deadCnt[1] <= changeReq[1] ? DEAD_LOAD : ((deadCnt[1] != '0) ? deadCnt[1] - 1'b1 : '0);
            enQ        <= reqEn & ~gapNow;
            pairQ[0]   <= gapNow[0] ? 2'b00 : reqPair[0];
            pairQ[1]   <= gapNow[1] ? 2'b00 : reqPair[1];
            pwmDbgQ    <= pwmVeer;
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enQ     <= '0;
            pairQ   <= '0;
            pwmDbgQ <= 1'b0;
        end else begin
            enQ     <= reqEn;
            pairQ   <= reqPair;
            pwmDbgQ <= pwmVeer;
        end
    end
`endif

    assign hb_en_a          = enQ[0];
    assign hb_en_b          = enQ[1];
    assign {hb_in1, hb_in2} = pairQ[0];
    assign {hb_in3, hb_in4} = pairQ[1];
    assign pwm_dbg          = pwmDbgQ;
    assign state            = stateQ;

endmodule

// File: tb/tb_drive_ctrl.sv
// Self-checking bench for drive_ctrl: scenario tasks plus a randomized steering reference model.
module tb_drive_ctrl;

    localparam int unsigned D = 20;

    logic       clk;
    logic       rst_n;
    logic [1:0] dir;
    logic       col_detect, junction, tone_valid;
    logic [2:0] tone_code;
    logic       hb_en_a, hb_en_b, hb_in1, hb_in2, hb_in3, hb_in4, pwm_dbg;
    logic [2:0] state;
    logic       x_en_a, x_en_b, x_in1, x_in2, x_in3, x_in4, x_dbg;
    logic [2:0] x_state;
    logic [3:0] pins;

    int checks = 0;
    int errors = 0;
    int k = 0;

    assign pins = {hb_in1, hb_in2, hb_in3, hb_in4};

    drive_ctrl #(
        .CLK_HZ(1000), .PWM_HZ(10), .CNT_W(7), .FULL_PCT(80), .VEER_PCT(40), .MAX_PCT(80),
        .TURN_CYCLES(300), .REV_CYCLES(500), .JUNCT_TIMEOUT(1000), .DEAD_CYCLES(D)
    ) dut (
        .clk(clk), .rst_n(rst_n), .dir(dir), .col_detect(col_detect), .junction(junction),
        .tone_valid(tone_valid), .tone_code(tone_code), .hb_en_a(hb_en_a), .hb_en_b(hb_en_b),
        .hb_in1(hb_in1), .hb_in2(hb_in2), .hb_in3(hb_in3), .hb_in4(hb_in4),
        .state(state), .pwm_dbg(pwm_dbg)
    );

    drive_ctrl #(
        .CLK_HZ(1000), .PWM_HZ(10), .CNT_W(7), .FULL_PCT(95), .VEER_PCT(40), .MAX_PCT(80),
        .TURN_CYCLES(300), .REV_CYCLES(500), .JUNCT_TIMEOUT(1000), .DEAD_CYCLES(D)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .dir(dir), .col_detect(col_detect), .junction(junction),
        .tone_valid(tone_valid), .tone_code(tone_code), .hb_en_a(x_en_a), .hb_en_b(x_en_b),
        .hb_in1(x_in1), .hb_in2(x_in2), .hb_in3(x_in3), .hb_in4(x_in4),
        .state(x_state), .pwm_dbg(x_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic doReset;
        rst_n = 1'b0;
        dir = 2'b00; col_detect = 1'b0; junction = 1'b0; tone_valid = 1'b0; tone_code = 3'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        k = 0;
    endtask

    task automatic enterJunction;
        junction = 1'b1;
        tick();
        junction = 1'b0;
    endtask

    task automatic test_reset;
        logic [10:0] got;
        repeat (37) tick();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        got = {hb_en_a, hb_en_b, pins, pwm_dbg, state, x_en_a};
        checks++;
        if (got !== 11'd0) begin
            errors++;
            $display("FAIL reset_async: got %b expected 0", got);
        end
        tick();
        got = {hb_en_a, hb_en_b, pins, pwm_dbg, state, x_en_a};
        checks++;
        if (got !== 11'd0) begin
            errors++;
            $display("FAIL reset_held: got %b expected 0", got);
        end
        @(negedge clk);
        rst_n = 1'b1;
        k = 0;
    endtask

    task automatic test_duty;
        int ca, cb, cd, c2a, c2b, badP, badS;
        ca = 0; cb = 0; cd = 0; c2a = 0; c2b = 0; badP = 0; badS = 0;
        dir = 2'b00;
        repeat (100) tick();
        for (int i = 0; i < 100; i++) begin
            tick();
            ca += int'(hb_en_a); cb += int'(hb_en_b); cd += int'(pwm_dbg);
            c2a += int'(x_en_a); c2b += int'(x_en_b);
            if (pins !== 4'b0110) badP++;
            if (state !== 3'd0) badS++;
        end
        checks++; if (ca != 80)  begin errors++; $display("FAIL duty_full_a: got %0d expected 80", ca); end
        checks++; if (cb != 80)  begin errors++; $display("FAIL duty_full_b: got %0d expected 80", cb); end
        checks++; if (cd != 40)  begin errors++; $display("FAIL duty_dbg: got %0d expected 40", cd); end
        checks++; if (c2a != 80) begin errors++; $display("FAIL duty_clamp_a: got %0d expected 80", c2a); end
        checks++; if (c2b != 80) begin errors++; $display("FAIL duty_clamp_b: got %0d expected 80", c2b); end
        checks++; if (badP != 0) begin errors++; $display("FAIL fwd_pins: got %0d bad cycles expected 0", badP); end
        checks++; if (badS != 0) begin errors++; $display("FAIL fwd_state: got %0d bad cycles expected 0", badS); end
    endtask

`ifndef DRIVE_DEADTIME_EN
    // Pins after edge k follow the dir seen two edges back and the PWM phase (k-1) mod 100.
    task automatic test_steer_random;
        logic [1:0] dqModel;
        logic [6:0] expV, gotV;
        logic       full, veer;
        int         ph;
        dqModel = dir;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) dir = 2'($urandom_range(0, 3));
            tick();
            ph   = (k - 1) % 100;
            full = (ph < 80);
            veer = (ph < 40);
            case (dqModel)
                2'b00:   expV = {full, full, 4'b0110, veer};
                2'b01:   expV = {veer, full, 4'b0110, veer};
                2'b10:   expV = {full, veer, 4'b0110, veer};
                default: expV = {2'b00, 4'b0000, veer};
            endcase
            gotV = {hb_en_a, hb_en_b, pins, pwm_dbg};
            checks++;
            if (gotV !== expV) begin
                errors++;
                $display("FAIL steer k=%0d dir=%b: got %b expected %b", k, dqModel, gotV, expV);
            end
            dqModel = dir;
        end
        dir = 2'b00;
        repeat (3) tick();
    endtask
`endif

    task automatic test_stop;
        logic [5:0] got;
        dir = 2'b11;
        tick();
        checks++;
        if (state !== 3'd0) begin errors++; $display("FAIL stop_state: got %0d expected 0", state); end
        tick();
        got = {hb_en_a, hb_en_b, pins};
        checks++;
        if (got !== 6'd0) begin errors++; $display("FAIL stop_pins: got %b expected 0", got); end
        dir = 2'b00;
        repeat (3) tick();
    endtask

    task automatic test_collision;
        int len, c1, badEn;
        len = $urandom_range(5, 15);
        c1 = 0; badEn = 0;
        col_detect = 1'b1;
        for (int i = 0; i < len; i++) begin
            tick();
            if (state == 3'd1) c1++;
            if (i >= 1 && (hb_en_a || hb_en_b)) badEn++;
        end
        col_detect = 1'b0;
        tick();
        checks++; if (c1 != len)   begin errors++; $display("FAIL coll_len: got %0d expected %0d", c1, len); end
        checks++; if (badEn != 0)  begin errors++; $display("FAIL coll_en: got %0d bad cycles expected 0", badEn); end
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL coll_exit: got %0d expected 0", state); end
        repeat (2) tick();
    endtask

    task automatic test_pivot(input logic [2:0] code, input int expLen, input logic [3:0] expP, input logic [2:0] expS);
        int w, n, ca, cb, badP, badJ;
        enterJunction();
        checks++; if (state !== 3'd2) begin errors++; $display("FAIL junct_enter: got %0d expected 2", state); end
        w = $urandom_range(2, 20);
        badJ = 0;
        for (int i = 0; i < w; i++) begin
            tick();
            if (hb_en_a || hb_en_b || state !== 3'd2) badJ++;
        end
        checks++; if (badJ != 0) begin errors++; $display("FAIL junct_wait: got %0d bad cycles expected 0", badJ); end
        tone_valid = 1'b1; tone_code = code;
        tick();
        tone_valid = 1'b0; tone_code = 3'($urandom_range(0, 7));
        n = 0; ca = 0; cb = 0; badP = 0;
        while (state == expS && n < 3000) begin
            n++;
            if (n >= 150 && n < 250) begin
                ca += int'(hb_en_a); cb += int'(hb_en_b);
                if (pins !== expP) badP++;
            end
            tick();
        end
        checks++; if (n != expLen)  begin errors++; $display("FAIL pivot_len code=%0d: got %0d expected %0d", code, n, expLen); end
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL pivot_exit: got %0d expected 0", state); end
        checks++; if (ca != 40)      begin errors++; $display("FAIL pivot_duty_a: got %0d expected 40", ca); end
        checks++; if (cb != 40)      begin errors++; $display("FAIL pivot_duty_b: got %0d expected 40", cb); end
        checks++; if (badP != 0)     begin errors++; $display("FAIL pivot_pins code=%0d: got %0d bad cycles expected 0", code, badP); end
        repeat (3) tick();
    endtask

    task automatic test_tone_misc;
        int badS;
        badS = 0;
        tone_valid = 1'b1; tone_code = 3'd4;
        tick();
        tone_valid = 1'b0;
        repeat (3) begin
            tick();
            if (state !== 3'd0) badS++;
        end
        checks++; if (badS != 0) begin errors++; $display("FAIL tone_outside: got %0d bad cycles expected 0", badS); end
        enterJunction();
        tone_valid = 1'b1; tone_code = 3'd1;
        tick();
        tone_valid = 1'b0;
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL tone_fwd: got %0d expected 0", state); end
        tick();
        enterJunction();
        col_detect = 1'b1; tone_valid = 1'b1; tone_code = 3'd4;
        tick();
        tone_valid = 1'b0;
        checks++; if (state !== 3'd1) begin errors++; $display("FAIL junct_col_prio: got %0d expected 1", state); end
        col_detect = 1'b0;
        tick();
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL junct_col_exit: got %0d expected 0", state); end
        tick();
    endtask

    task automatic test_tone_at_timeout;
        enterJunction();
        repeat (999) tick();
        checks++; if (state !== 3'd2) begin errors++; $display("FAIL edge_wait: got %0d expected 2", state); end
        tone_valid = 1'b1; tone_code = 3'd1;
        tick();
        tone_valid = 1'b0;
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL tone_vs_timeout: got %0d expected 0", state); end
        tick();
    endtask

    task automatic test_halt_code;
        logic [2:0] code;
        case ($urandom_range(0, 3))
            0: code = 3'd0;
            1: code = 3'd5;
            2: code = 3'd6;
            default: code = 3'd7;
        endcase
        enterJunction();
        tone_valid = 1'b1; tone_code = code;
        tick();
        tone_valid = 1'b0;
        checks++; if (state !== 3'd5) begin errors++; $display("FAIL halt_code %0d: got %0d expected 5", code, state); end
        doReset();
    endtask

    task automatic test_timeout;
        int n, bad;
        repeat (5) tick();
        enterJunction();
        n = 0;
        while (state == 3'd2 && n < 3000) begin
            n++;
            tick();
        end
        checks++; if (n != 1000)      begin errors++; $display("FAIL timeout_len: got %0d expected 1000", n); end
        checks++; if (state !== 3'd5) begin errors++; $display("FAIL timeout_halt: got %0d expected 5", state); end
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            col_detect = 1'($urandom_range(0, 1));
            junction   = 1'($urandom_range(0, 1));
            tone_valid = 1'($urandom_range(0, 1));
            tone_code  = 3'($urandom_range(0, 7));
            dir        = 2'($urandom_range(0, 3));
            tick();
            if (state !== 3'd5 || hb_en_a || hb_en_b || pins !== 4'b0000) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL halt_sticky: got %0d bad cycles expected 0", bad); end
        doReset();
        tick();
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL halt_reset: got %0d expected 0", state); end
    endtask

`ifdef DRIVE_DEADTIME_EN
    task automatic test_deadtime;
        int bad, ca, cb, n;
        dir = 2'b00;
        repeat (60) tick();
        enterJunction();
        repeat (3) tick();
        tone_valid = 1'b1; tone_code = 3'd4;
        tick();
        tone_valid = 1'b0;
        checks++; if (state !== 3'd4) begin errors++; $display("FAIL dt_rev_state: got %0d expected 4", state); end
        bad = 0;
        for (int j = 0; j < int'(D); j++) begin
            tick();
            if ({hb_en_a, hb_en_b, pins} !== 6'd0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL dt_gap: got %0d bad cycles expected 0", bad); end
        tick();
        checks++; if (pins !== 4'b1001) begin errors++; $display("FAIL dt_after: got %b expected 1001", pins); end
        ca = 0; cb = 0;
        for (int j = 0; j < 100; j++) begin
            tick();
            ca += int'(hb_en_a); cb += int'(hb_en_b);
        end
        checks++; if (ca != 40) begin errors++; $display("FAIL dt_duty_a: got %0d expected 40", ca); end
        checks++; if (cb != 40) begin errors++; $display("FAIL dt_duty_b: got %0d expected 40", cb); end
        n = 0;
        while (state == 3'd4 && n < 1000) begin
            n++;
            tick();
        end
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL dt_rev_exit: got %0d expected 0", state); end
    endtask
`endif

    initial begin
        doReset();
        test_reset();
        test_duty();
`ifndef DRIVE_DEADTIME_EN
        test_steer_random();
`endif
        test_stop();
        test_collision();
        test_collision();
        test_pivot(3'd2, 300, 4'b1010, 3'd3);
        test_pivot(3'd3, 300, 4'b0101, 3'd3);
        test_pivot(3'd4, 500, 4'b1001, 3'd4);
        test_tone_misc();
        test_tone_at_timeout();
        test_halt_code();
        test_timeout();
`ifdef DRIVE_DEADTIME_EN
        test_deadtime();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
